// File: rtl/bram_init_sequencer.sv
// rtl/bram_init_sequencer.sv - BlockRAM init sweep after reset/clear, then transparent client pass-through
module bram_init_sequencer #(
    parameter int                Width     = 8,
    parameter int                Depth     = 8,
    parameter int                AddrWidth = 8,
    parameter logic [Width-1:0]  InitValue = '0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           clear,
    output logic                           init_done,
    input  logic [AddrWidth+Width:0]       client_req,
    input  logic                           client_req_valid,
    output logic                           client_req_bp,
    output logic [Width-1:0]               client_resp,
    output logic                           client_resp_valid,
    input  logic                           client_resp_bp,
    output logic [AddrWidth+Width:0]       mem_req,
    output logic                           mem_req_valid,
    input  logic                           mem_req_bp,
    input  logic [Width-1:0]               mem_resp,
    input  logic                           mem_resp_valid,
    output logic                           mem_resp_bp
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AddrWidth-1:0] r_cnt;
    logic [AddrWidth-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are gated by resetn so the RAM sees no request while reset is held.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        mem_req           = {r_cnt, InitValue, 1'b1};
        mem_req_valid     = 1'b0;
        client_req_bp     = 1'b1;
        client_resp       = mem_resp;
        client_resp_valid = 1'b0;
        mem_resp_bp       = 1'b0;
        init_done         = 1'b0;
        if (resetn) begin
            case (r_state)
                ST_INIT: begin
                    mem_req_valid = 1'b1;
                    if (!mem_req_bp) begin
                        if (r_cnt == LastAddr) begin
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    init_done         = 1'b1;
                    mem_req           = client_req;
                    mem_req_valid     = client_req_valid;
                    client_req_bp     = mem_req_bp;
                    client_resp_valid = mem_resp_valid;
                    mem_resp_bp       = client_resp_bp;
                    if (clear) begin
                        w_state_nxt = ST_INIT;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_init_sequencer.sv
// tb/tb_bram_init_sequencer.sv - self-checking bench for bram_init_sequencer with a behavioural RAM
module tb_bram_init_sequencer;

    localparam int              W     = 8;
    localparam int              A     = 8;
    localparam int              DEPTH = 8;
    localparam logic [W-1:0]    INITV = 8'hA5;
    localparam int              RW    = W + A + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clear = 1'b0;
    logic          init_done;
    logic [RW-1:0] client_req = '0;
    logic          client_req_valid = 1'b0;
    logic          client_req_bp;
    logic [W-1:0]  client_resp;
    logic          client_resp_valid;
    logic          client_resp_bp = 1'b0;
    logic [RW-1:0] mem_req;
    logic          mem_req_valid;
    logic          mem_req_bp = 1'b0;
    logic [W-1:0]  mem_resp;
    logic          mem_resp_valid;
    logic          mem_resp_bp;

    logic [W-1:0]  ram     [0:(1<<A)-1];
    logic [W-1:0]  exp_mem [0:(1<<A)-1];
    int            n_assert = 0;
    int            n_fail   = 0;

    bram_init_sequencer #(
        .Width(W), .Depth(DEPTH), .AddrWidth(A), .InitValue(INITV)
    ) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .init_done(init_done),
        .client_req(client_req), .client_req_valid(client_req_valid),
        .client_req_bp(client_req_bp), .client_resp(client_resp),
        .client_resp_valid(client_resp_valid), .client_resp_bp(client_resp_bp),
        .mem_req(mem_req), .mem_req_valid(mem_req_valid), .mem_req_bp(mem_req_bp),
        .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid), .mem_resp_bp(mem_resp_bp)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read response, write on accepted request.
    assign mem_resp       = ram[mem_req[RW-1:W+1]];
    assign mem_resp_valid = mem_req_valid && !mem_req_bp && !mem_req[0];
    always @(posedge clk)
        if (mem_req_valid && !mem_req_bp && mem_req[0])
            ram[mem_req[RW-1:W+1]] <= mem_req[W:1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 0);
        check({tag, "_client_req_bp"}, 32'(client_req_bp), 1);
        check({tag, "_client_resp_valid"}, 32'(client_resp_valid), 0);
        check({tag, "_init_done"}, 32'(init_done), 0);
        check({tag, "_mem_resp_bp"}, 32'(mem_resp_bp), 0);
    endtask

    // Sweep reference: one write per accepted cycle, addresses 0..DEPTH-1 in order, then RUN.
    task automatic do_sweep(input string tag, input int stall_addr, input int stall_cycles,
                            input int clr_cycle);
        int acc = 0;
        int cyc = 0;
        int stalled = 0;
        while (acc < DEPTH && cyc < 200) begin
            mem_req_bp = (acc == stall_addr) && (stalled < stall_cycles);
            clear      = (cyc == clr_cycle);
            #1;
            check({tag, "_valid"}, 32'(mem_req_valid), 1);
            check({tag, "_req"}, 32'(mem_req), 32'({8'(acc), INITV, 1'b1}));
            check({tag, "_client_bp"}, 32'(client_req_bp), 1);
            check({tag, "_client_rv"}, 32'(client_resp_valid), 0);
            check({tag, "_done_low"}, 32'(init_done), 0);
            if (mem_req_bp) stalled++;
            else            acc++;
            @(negedge clk);
            cyc++;
        end
        mem_req_bp = 1'b0;
        clear      = 1'b0;
        #1;
        check({tag, "_cycles"}, 32'(cyc), 32'(DEPTH + stall_cycles));
        check({tag, "_done"}, 32'(init_done), 1);
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = INITV;
    endtask

    task automatic client_op(input string tag, input logic wr, input logic [A-1:0] addr,
                             input logic [W-1:0] data, input logic valid, input logic rbp,
                             input logic cbp);
        client_req       = {addr, data, wr};
        client_req_valid = valid;
        mem_req_bp       = rbp;
        client_resp_bp   = cbp;
        #1;
        check({tag, "_mem_req"}, 32'(mem_req), 32'({addr, data, wr}));
        check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'(valid));
        check({tag, "_client_bp"}, 32'(client_req_bp), 32'(rbp));
        check({tag, "_mem_resp_bp"}, 32'(mem_resp_bp), 32'(cbp));
        check({tag, "_resp_valid"}, 32'(client_resp_valid), 32'(valid && !rbp && !wr));
        if (valid && !rbp && !wr)
            check({tag, "_resp"}, 32'(client_resp), 32'(exp_mem[addr]));
        if (valid && !rbp && wr) exp_mem[addr] = data;
        @(negedge clk);
        client_req_valid = 1'b0;
        mem_req_bp       = 1'b0;
        client_resp_bp   = 1'b0;
    endtask

    task automatic start_clear(input string tag);
        client_req_valid = 1'b0;
        clear            = 1'b1;
        #1;
        check({tag, "_done_before_clear"}, 32'(init_done), 1);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < (1 << A); a++) begin
            ram[a]     = W'($urandom);
            exp_mem[a] = ram[a];
        end

        // Reset held: outputs quiet, client held off
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // Sweep after reset, with a client read of addr 3 pending throughout
        client_req       = {8'd3, 8'h00, 1'b0};
        client_req_valid = 1'b1;
        resetn           = 1'b1;
        do_sweep("sweep1", -1, 0, -1);
        check("t2_passthru_req", 32'(mem_req), 32'({8'd3, 8'h00, 1'b0}));
        check("t2_passthru_valid", 32'(mem_req_valid), 1);
        check("t2_client_bp", 32'(client_req_bp), 0);
        check("t2_resp_valid", 32'(client_resp_valid), 1);
        check("t2_resp", 32'(client_resp), 32'(INITV));
        @(negedge clk);
        client_req_valid = 1'b0;

        // Directed write then read of addr 5
        client_op("t3_wr", 1'b1, 8'd5, 8'h3C, 1'b1, 1'b0, 1'b0);
        client_op("t3_rd", 1'b0, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t3_ram5", 32'(ram[5]), 32'h3C);

        // Randomised pass-through traffic
        for (int k = 0; k < 24; k++)
            client_op("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      8'($urandom), ($urandom_range(0, 4) != 0),
                      ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

        // Backpressure at cnt==2 for 3 cycles; clear mid-sweep must be ignored
        start_clear("t4");
        do_sweep("sweep_stall", 2, 3, 4);

        // Clear coincident with an accepted client write to addr 1
        client_req       = {8'd1, 8'h11, 1'b1};
        client_req_valid = 1'b1;
        clear            = 1'b1;
        #1;
        check("t5_client_bp", 32'(client_req_bp), 0);
        check("t5_mem_req", 32'(mem_req), 32'({8'd1, 8'h11, 1'b1}));
        @(negedge clk);
        clear            = 1'b0;
        client_req_valid = 1'b0;
        check("t5_write_landed", 32'(ram[1]), 32'h11);
        do_sweep("sweep_clr", -1, 0, -1);
        client_op("t5_rd", 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t5_ram1", 32'(ram[1]), 32'(INITV));

        // Reset after four sweep writes: sweep restarts at address 0
        for (int a = 0; a < (1 << A); a++) begin
            ram[a]     = W'($urandom);
            exp_mem[a] = ram[a];
        end
        start_clear("t6");
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t6_pre_req", 32'(mem_req), 32'({8'(i), INITV, 1'b1}));
            @(negedge clk);
        end
        for (int a = 0; a < 4; a++) exp_mem[a] = INITV;
        resetn = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        @(negedge clk);
        resetn = 1'b1;
        do_sweep("sweep_rst", -1, 0, -1);

        // Whole RAM against the reference: nothing beyond DEPTH touched by sweeps
        for (int a = 0; a < (1 << A); a++)
            check("final_ram", 32'(ram[a]), 32'(exp_mem[a]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
